decode_control_stage: RTL and testbench

DECODE_CONTROL_STAGE -- requirements
Module: decode_control_stage

---
 rtl/decode_control_stage_if.sv | 36 +++
 rtl/decode_control_stage.sv | 133 +++++++++++++
 tb/tb_decode_control_stage.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/decode_control_stage_if.sv
// Fetch/decode bus between the IF/ID stage, the control decoder and its consumers.
interface decode_control_stage_if;
  logic [31:0] instr_in;
  logic        if_id_en;
  logic [31:0] instruction;
  logic        Reg2Loc;
  logic        ALUsrc;
  logic        ALUsrc1;
  logic        MemtoReg;
  logic        RegWrite;
  logic        MemWri;
  logic        Readmem;
  logic        enFlags;
  logic        WriteRd;
  logic        UncondBr;
  logic        BR;
  logic [2:0]  ALUOp;
  logic [4:0]  rd_id;
  logic [4:0]  rd_ex;
  logic [4:0]  rd_mem;
  logic [4:0]  rd_wb;

  modport master (
    output instr_in, if_id_en,
    input  instruction, Reg2Loc, ALUsrc, ALUsrc1, MemtoReg, RegWrite, MemWri,
           Readmem, enFlags, WriteRd, UncondBr, BR, ALUOp,
           rd_id, rd_ex, rd_mem, rd_wb
  );

  modport slave (
    input  instr_in, if_id_en,
    output instruction, Reg2Loc, ALUsrc, ALUsrc1, MemtoReg, RegWrite, MemWri,
           Readmem, enFlags, WriteRd, UncondBr, BR, ALUOp,
           rd_id, rd_ex, rd_mem, rd_wb
  );
endinterface

// File: rtl/decode_control_stage.sv
// IF/ID instruction register, combinational control decode and the
// destination-register pipeline (ID -> EX -> MEM -> WB).
module decode_control_stage (
  input  logic                          clk,
  input  logic                          reset,
  decode_control_stage_if.slave         bus
);

  typedef enum logic [3:0] {
    OP_NOP, OP_ADDI, OP_ADDS, OP_SUBS, OP_LDUR, OP_STUR,
    OP_BR, OP_B, OP_BL, OP_BCOND, OP_CBZ
  } op_e;

  logic [31:0] instr_q, instr_d;
  logic [4:0]  rd_ex_q, rd_mem_q, rd_wb_q;
  logic [4:0]  rd_id;
  op_e         op;

  // IF/ID next-state: load when enabled, otherwise hold (stall).
  always_comb begin
    instr_d = instr_q;
    if (bus.if_id_en) instr_d = bus.instr_in;
  end

  // IF/ID register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) instr_q <= '0;
    else        instr_q <= instr_d;
  end

  // Opcode classification; 11-bit patterns are tested first so they win.
  always_comb begin
    op = OP_NOP;
    if      (instr_q[31:21] == 11'b10101011000) op = OP_ADDS;
    else if (instr_q[31:21] == 11'b11101011000) op = OP_SUBS;
    else if (instr_q[31:21] == 11'b11111000010) op = OP_LDUR;
    else if (instr_q[31:21] == 11'b11111000000) op = OP_STUR;
    else if (instr_q[31:21] == 11'b11010110000) op = OP_BR;
    else if (instr_q[31:22] == 10'b1001000100)  op = OP_ADDI;
    else if (instr_q[31:24] == 8'b01010100)     op = OP_BCOND;
    else if (instr_q[31:24] == 8'b10110100)     op = OP_CBZ;
    else if (instr_q[31:26] == 6'b000101)       op = OP_B;
    else if (instr_q[31:26] == 6'b100101)       op = OP_BL;
  end

  // Control outputs from the decoded class; defaults give the NOP decode.
  always_comb begin
    bus.Reg2Loc  = 1'b1;
    bus.ALUsrc   = 1'b0;
    bus.ALUsrc1  = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.RegWrite = 1'b0;
    bus.MemWri   = 1'b0;
    bus.Readmem  = 1'b0;
    bus.enFlags  = 1'b0;
    bus.WriteRd  = 1'b1;
    bus.UncondBr = 1'b0;
    bus.BR       = 1'b0;
    bus.ALUOp    = 3'b000;
    unique case (op)
      OP_ADDI: begin
        bus.ALUsrc   = 1'b1;
        bus.ALUsrc1  = 1'b1;
        bus.RegWrite = 1'b1;
        bus.ALUOp    = 3'b010;
      end
      OP_ADDS: begin
        bus.RegWrite = 1'b1;
        bus.enFlags  = 1'b1;
        bus.ALUOp    = 3'b010;
      end
      OP_SUBS: begin
        bus.RegWrite = 1'b1;
        bus.enFlags  = 1'b1;
        bus.ALUOp    = 3'b011;
      end
      OP_LDUR: begin
        bus.ALUsrc   = 1'b1;
        bus.MemtoReg = 1'b1;
        bus.RegWrite = 1'b1;
        bus.Readmem  = 1'b1;
        bus.ALUOp    = 3'b010;
      end
      OP_STUR: begin
        bus.Reg2Loc  = 1'b0;
        bus.ALUsrc   = 1'b1;
        bus.MemWri   = 1'b1;
        bus.ALUOp    = 3'b010;
      end
      OP_B: begin
        bus.UncondBr = 1'b1;
      end
      OP_BL: begin
        bus.UncondBr = 1'b1;
        bus.RegWrite = 1'b1;
        bus.WriteRd  = 1'b0;
      end
      OP_CBZ: begin
        bus.Reg2Loc  = 1'b0;
      end
      OP_BR: begin
        bus.Reg2Loc  = 1'b0;
        bus.BR       = 1'b1;
      end
      default: ;
    endcase
  end

  // Destination select: BL writes the link register X30.
  always_comb begin
    rd_id = bus.WriteRd ? instr_q[4:0] : 5'd30;
  end

  // Destination pipeline shifts every edge regardless of the stall enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ex_q  <= '0;
      rd_mem_q <= '0;
      rd_wb_q  <= '0;
    end else begin
      rd_ex_q  <= rd_id;
      rd_mem_q <= rd_ex_q;
      rd_wb_q  <= rd_mem_q;
    end
  end

  assign bus.instruction = instr_q;
  assign bus.rd_id       = rd_id;
  assign bus.rd_ex       = rd_ex_q;
  assign bus.rd_mem      = rd_mem_q;
  assign bus.rd_wb       = rd_wb_q;

endmodule

// File: tb/tb_decode_control_stage.sv
// Directed bench for decode_control_stage with hand-computed expectations.
module tb_decode_control_stage;

  logic clk;
  logic reset;
  int unsigned n_checks;
  int unsigned n_fail;

  decode_control_stage_if bus ();

  decode_control_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs control outputs as {Reg2Loc,ALUsrc,ALUsrc1,MemtoReg,RegWrite,MemWri,
  // Readmem,enFlags,WriteRd,UncondBr,BR,ALUOp[2:0]}.
  function automatic logic [13:0] mk(input logic r2l, als, als1, m2r, rw, mw,
                                     rm, ef, wrd, ub, br, input logic [2:0] op);
    return {r2l, als, als1, m2r, rw, mw, rm, ef, wrd, ub, br, op};
  endfunction

  function automatic logic [13:0] ctl_now();
    return {bus.Reg2Loc, bus.ALUsrc, bus.ALUsrc1, bus.MemtoReg, bus.RegWrite,
            bus.MemWri, bus.Readmem, bus.enFlags, bus.WriteRd, bus.UncondBr,
            bus.BR, bus.ALUOp};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a word on negedge, then sample 1 time unit after the next rising edge.
  task automatic drive(input logic [31:0] w, input logic en);
    @(negedge clk);
    bus.instr_in = w;
    bus.if_id_en = en;
    @(posedge clk);
    #1;
  endtask

  logic [13:0] NOP_C, ADDS_C, SUBS_C, LDUR_C, STUR_C, BL_C, CBZ_C, ADDI_C, B_C, BR_C;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    NOP_C  = mk(1,0,0,0,0,0,0,0,1,0,0,3'b000);
    ADDS_C = mk(1,0,0,0,1,0,0,1,1,0,0,3'b010);
    SUBS_C = mk(1,0,0,0,1,0,0,1,1,0,0,3'b011);
    LDUR_C = mk(1,1,0,1,1,0,1,0,1,0,0,3'b010);
    STUR_C = mk(0,1,0,0,0,1,0,0,1,0,0,3'b010);
    BL_C   = mk(1,0,0,0,1,0,0,0,0,1,0,3'b000);
    CBZ_C  = mk(0,0,0,0,0,0,0,0,1,0,0,3'b000);
    ADDI_C = mk(1,1,1,0,1,0,0,0,1,0,0,3'b010);
    B_C    = mk(1,0,0,0,0,0,0,0,1,1,0,3'b000);
    BR_C   = mk(0,0,0,0,0,0,0,0,1,0,1,3'b000);

    reset        = 1'b0;
    bus.instr_in = 32'h0;
    bus.if_id_en = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_instr",  bus.instruction, 32'h0);
    check("rst_rd_ex",  bus.rd_ex, 0);
    check("rst_rd_mem", bus.rd_mem, 0);
    check("rst_rd_wb",  bus.rd_wb, 0);
    check("rst_rd_id",  bus.rd_id, 0);
    check("rst_ctl",    ctl_now(), NOP_C);
    reset = 1'b1;

    // ADDS X3,X1,X2 and its walk down the destination pipeline.
    drive(32'hAB020023, 1'b1);
    check("adds_instr", bus.instruction, 32'hAB020023);
    check("adds_ctl",   ctl_now(), ADDS_C);
    check("adds_rd_id", bus.rd_id, 3);
    check("adds_rd_ex0", bus.rd_ex, 0);
    drive(32'hAB020023, 1'b1);
    check("adds_rd_ex",  bus.rd_ex, 3);
    check("adds_rd_mem0", bus.rd_mem, 0);
    drive(32'hAB020023, 1'b1);
    check("adds_rd_mem", bus.rd_mem, 3);
    check("adds_rd_wb0", bus.rd_wb, 0);
    drive(32'hAB020023, 1'b1);
    check("adds_rd_wb",  bus.rd_wb, 3);

    drive(32'hEB020023, 1'b1);
    check("subs_ctl", ctl_now(), SUBS_C);

    drive(32'hF8408025, 1'b1);
    check("ldur_ctl",   ctl_now(), LDUR_C);
    check("ldur_rd_id", bus.rd_id, 5);
    drive(32'hF8008025, 1'b1);
    check("stur_ctl",   ctl_now(), STUR_C);

    drive(32'h94000004, 1'b1);
    check("bl_ctl",   ctl_now(), BL_C);
    check("bl_rd_id", bus.rd_id, 30);
    drive(32'hB4000062, 1'b1);
    check("cbz_ctl",   ctl_now(), CBZ_C);
    check("cbz_rd_id", bus.rd_id, 2);
    check("cbz_rd_ex", bus.rd_ex, 30);

    drive(32'h14000001, 1'b1);
    check("b_ctl", ctl_now(), B_C);
    drive(32'h54000040, 1'b1);
    check("bcond_ctl", ctl_now(), NOP_C);
    drive(32'hD61F0000, 1'b1);
    check("br_ctl", ctl_now(), BR_C);

    // ADDI then a 3-edge stall with instr_in changing underneath.
    drive(32'h910004E7, 1'b1);
    check("addi_ctl",   ctl_now(), ADDI_C);
    check("addi_rd_id", bus.rd_id, 7);
    drive(32'hAB020023, 1'b0);
    check("stall1_instr", bus.instruction, 32'h910004E7);
    check("stall1_rd_ex", bus.rd_ex, 7);
    drive(32'hF8008025, 1'b0);
    check("stall2_ctl",    ctl_now(), ADDI_C);
    check("stall2_rd_mem", bus.rd_mem, 7);
    drive(32'h94000004, 1'b0);
    check("stall3_instr", bus.instruction, 32'h910004E7);
    check("stall3_rd_id", bus.rd_id, 7);
    check("stall3_rd_ex", bus.rd_ex, 7);
    check("stall3_rd_mem", bus.rd_mem, 7);
    check("stall3_rd_wb", bus.rd_wb, 7);

    // Unmatched word decodes as NOP; let it fill the pipeline.
    drive(32'hFFFFFFFF, 1'b1);
    check("ones_ctl",   ctl_now(), NOP_C);
    check("ones_rd_id", bus.rd_id, 31);
    drive(32'hFFFFFFFF, 1'b1);
    drive(32'hFFFFFFFF, 1'b1);
    drive(32'hFFFFFFFF, 1'b1);
    check("pre_rst_rd_wb", bus.rd_wb, 31);

    // Asynchronous reset between edges, held across an enabled edge.
    #2;
    reset = 1'b0;
    #1;
    check("arst_instr",  bus.instruction, 32'h0);
    check("arst_rd_ex",  bus.rd_ex, 0);
    check("arst_rd_mem", bus.rd_mem, 0);
    check("arst_rd_wb",  bus.rd_wb, 0);
    check("arst_rd_id",  bus.rd_id, 0);
    check("arst_ctl",    ctl_now(), NOP_C);
    drive(32'hAB020023, 1'b1);
    check("arst_override", bus.instruction, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_load", bus.instruction, 32'hAB020023);
    check("post_rst_ctl",  ctl_now(), ADDS_C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
